// File: rtl/fetch_line_scheduler_if.sv
// Line-read port toward the I$ plus the fill strobe toward the fetch-buffer datapath.
interface fetch_line_scheduler_if #(
    parameter int unsigned PA_BITS = 34
) ();
    logic               CacheReq;
    logic [PA_BITS-1:0] CachePAdr;
    logic               CacheReady;
    logic               CacheRspValid;
    logic               FillEn;
    logic               FillSlot;

    modport master (
        output CacheReq, CachePAdr, FillEn, FillSlot,
        input  CacheReady, CacheRspValid
    );

    modport slave (
        input  CacheReq, CachePAdr, FillEn, FillSlot,
        output CacheReady, CacheRspValid
    );
endinterface

// File: rtl/fetch_line_scheduler.sv
// Two-slot fetch buffer controller: slot tags/valids, demand hit detection and
// arbitration of the single I$ line-read port between demand misses and prefetches.
module fetch_line_scheduler #(
    parameter int unsigned PA_BITS = 34,
    parameter int unsigned LINELEN = 512
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   DemandValid,
    input  logic [PA_BITS-1:0]     DemandPAdr,
    input  logic                   PrefetchHint,
    input  logic                   Stall,
    input  logic                   FlushStage,
    fetch_line_scheduler_if.master cache,
    output logic                   Hit,
    output logic                   HitSlot,
    output logic                   ActiveSlot,
    output logic [1:0]             SlotValid,
    output logic                   StallFB
);
    localparam int unsigned OFS   = $clog2(LINELEN / 8);
    localparam int unsigned TAG_W = PA_BITS - OFS;

    typedef enum logic [2:0] {IDLE, DREQ, DWAIT, PREQ, PWAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] slot_tag_q [2];
    logic [1:0]       slot_valid_q;
    logic             active_q;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic             req_slot_q, req_slot_d;
    logic             issue_c, fill_c, req_c;

    logic             demand_v;
    logic [TAG_W-1:0] line_tag, next_tag;
    logic [1:0]       match, next_match;
    logic             line_max, demand_miss, prefetch_ok;
    logic             unused_ofs;

    // Demand side is ignored while reset is held so Hit/StallFB read as 0.
    assign demand_v = DemandValid & reset_n;
    assign line_tag = DemandPAdr[PA_BITS-1:OFS];
    assign next_tag = line_tag + TAG_W'(1);
    assign line_max = &line_tag;
    assign unused_ofs = ^DemandPAdr[OFS-1:0];

    assign match[0]      = slot_valid_q[0] & (slot_tag_q[0] == line_tag);
    assign match[1]      = slot_valid_q[1] & (slot_tag_q[1] == line_tag);
    assign next_match[0] = slot_valid_q[0] & (slot_tag_q[0] == next_tag);
    assign next_match[1] = slot_valid_q[1] & (slot_tag_q[1] == next_tag);

    assign Hit        = demand_v & (|match);
    assign HitSlot    = ~match[0] & match[1];
    assign StallFB    = demand_v & ~Hit;
    assign ActiveSlot = active_q;
    assign SlotValid  = slot_valid_q;

    assign demand_miss = demand_v & ~Hit & ~Stall & ~FlushStage;
    assign prefetch_ok = Hit & PrefetchHint & ~Stall & ~FlushStage & ~(|next_match) & ~line_max;

    assign cache.CacheReq  = req_c;
    assign cache.CachePAdr = {req_tag_q, {OFS{1'b0}}};
    assign cache.FillEn    = fill_c;
    assign cache.FillSlot  = req_slot_q;

    // State and request registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            req_tag_q  <= '0;
            req_slot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            req_slot_q <= req_slot_d;
        end
    end

    // Next-state, request issue and fill control
    always_comb begin
        state_d    = state_q;
        req_tag_d  = req_tag_q;
        req_slot_d = req_slot_q;
        issue_c    = 1'b0;
        fill_c     = 1'b0;
        req_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (demand_miss) begin
                    req_tag_d  = line_tag;
                    req_slot_d = ~active_q;
                    issue_c    = 1'b1;
                    state_d    = DREQ;
                end else if (prefetch_ok) begin
                    req_tag_d  = next_tag;
                    req_slot_d = ~HitSlot;
                    issue_c    = 1'b1;
                    state_d    = PREQ;
                end
            end
            DREQ, PREQ: begin
                // A flush withdraws the request before the cache can accept it.
                if (FlushStage) begin
                    state_d = IDLE;
                end else begin
                    req_c = 1'b1;
                    if (cache.CacheReady) state_d = (state_q == DREQ) ? DWAIT : PWAIT;
                end
            end
            DWAIT, PWAIT: begin
                if (FlushStage) begin
                    state_d = cache.CacheRspValid ? IDLE : DRAIN;
                end else if (cache.CacheRspValid) begin
                    fill_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cache.CacheRspValid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot tags, valid bits and active slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_tag_q[0] <= '0;
            slot_tag_q[1] <= '0;
            slot_valid_q  <= '0;
            active_q      <= 1'b0;
        end else if (FlushStage) begin
            slot_valid_q <= '0;
            active_q     <= 1'b0;
        end else begin
            if (issue_c) slot_valid_q[req_slot_d] <= 1'b0;
            if (fill_c) begin
                slot_valid_q[req_slot_q] <= 1'b1;
                slot_tag_q[req_slot_q]   <= req_tag_q;
            end
            if (Hit && !Stall) active_q <= HitSlot;
        end
    end
endmodule
